// File: rtl/csr_bus_arbiter.sv
// Two-master round-robin arbiter in front of the CSR local register bus.
// One transaction in flight at a time; a watchdog force-completes hung accesses with err.
module csr_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W/8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_wen,
  output logic [ADDR_W-1:0] s_waddr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wready,
  output logic              s_ren,
  output logic [ADDR_W-1:0] s_raddr,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              busy
);
  localparam int WDOG_W = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT-1);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } cmd_t;

  state_t            state, state_n;
  cmd_t              cmd, req_cmd;
  logic              gnt, last_grant, err_q;
  logic              any_req, pick, pick_we, wd_exp;
  logic [WDOG_W-1:0] wdog;

  // Tie goes to the master that was not served last.
  always_comb begin
    any_req       = m0_req || m1_req;
    pick          = (m0_req && m1_req) ? ~last_grant : m1_req;
    pick_we       = pick ? m1_we : m0_we;
    req_cmd.addr  = pick ? m1_addr  : m0_addr;
    req_cmd.wdata = pick ? m1_wdata : m0_wdata;
    req_cmd.wstrb = pick ? m1_wstrb : m0_wstrb;
    wd_exp        = (wdog == WDOG_MAX);
  end

  always_comb begin
    state_n = state;
    s_wen   = 1'b0;
    s_ren   = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_err  = 1'b0;
    case (state)
      IDLE: if (any_req) state_n = pick_we ? WR : RD;
      WR: begin
        s_wen = 1'b1;
        if (s_wready || wd_exp) state_n = DONE;
      end
      RD: begin
        s_ren = 1'b1;
        if (s_rvalid || wd_exp) state_n = DONE;
      end
      DONE: begin
        m0_ack  = !gnt;
        m1_ack  = gnt;
        m0_err  = !gnt && err_q;
        m1_err  = gnt && err_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Slave address/data come only from the latched command.
  assign s_waddr = cmd.addr;
  assign s_wdata = cmd.wdata;
  assign s_wstrb = cmd.wstrb;
  assign s_raddr = cmd.addr;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      wdog       <= '0;
      err_q      <= 1'b0;
      cmd        <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (any_req) begin
          cmd        <= req_cmd;
          gnt        <= pick;
          last_grant <= pick;
          wdog       <= '0;
        end
        WR: begin
          if (s_wready)    err_q <= 1'b0;
          else if (wd_exp) err_q <= 1'b1;
          else             wdog  <= wdog + WDOG_W'(1);
        end
        RD: begin
          if (s_rvalid) begin
            err_q <= 1'b0;
            if (gnt) m1_rdata <= s_rdata;
            else     m0_rdata <= s_rdata;
          end else if (wd_exp) begin
            err_q <= 1'b1;
            if (gnt) m1_rdata <= '0;
            else     m0_rdata <= '0;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Directed bench for csr_bus_arbiter: transaction vector table plus
// hand sequences for reset-during-read and round-robin alternation.
module tb_csr_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_wen, s_wready, s_ren, s_rvalid, busy;
  logic [15:0] s_waddr, s_raddr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  int          errors = 0;
  int          checks = 0;
  int          wlat = 0, rlat = 1, scnt = 0;
  logic [31:0] sdata = '0;

  csr_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_wen(s_wen), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wready(s_wready), .s_ren(s_ren), .s_raddr(s_raddr), .s_rdata(s_rdata),
    .s_rvalid(s_rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave model: answers after wlat/rlat strobe cycles (large lat = never).
  always @(posedge clk) begin
    if (rst || !(s_wen || s_ren)) scnt <= 0;
    else                          scnt <= scnt + 1;
  end
  assign s_wready = s_wen && (scnt == wlat);
  assign s_rvalid = s_ren && (scnt == rlat);
  assign s_rdata  = sdata;

  typedef struct {
    bit          m;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          lat;
    logic [31:0] sdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    int          exp_strobes;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int cyc, strobes;
    bit acked, other_ack, both;
    logic [15:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    @(negedge clk);
    wlat = v.lat; rlat = v.lat; sdata = v.sdata;
    if (v.m) begin
      m1_req = 1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_wstrb = v.strb;
    end else begin
      m0_req = 1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_wstrb = v.strb;
    end
    cyc = 0; strobes = 0; acked = 0; other_ack = 0; both = 0;
    wa = '0; wd = '0; ws = '0;
    while (!acked && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (s_wen || s_ren) strobes++;
      if (s_wen) begin wa = s_waddr; wd = s_wdata; ws = s_wstrb; end
      if (s_wen && s_ren) both = 1;
      if (v.m ? m0_ack : m1_ack) other_ack = 1;
      if (v.m ? m1_ack : m0_ack) acked = 1;
    end
    m0_req = 0; m1_req = 0;
    chk($sformatf("v%0d_acked", i), 32'(acked), 32'd1);
    chk($sformatf("v%0d_ack_cycle", i), cyc, v.exp_cyc);
    chk($sformatf("v%0d_err", i), 32'(v.m ? m1_err : m0_err), 32'(v.exp_err));
    chk($sformatf("v%0d_rdata", i), v.m ? m1_rdata : m0_rdata, v.exp_rdata);
    chk($sformatf("v%0d_strobe_cycles", i), strobes, v.exp_strobes);
    chk($sformatf("v%0d_other_ack", i), 32'(other_ack), 32'd0);
    chk($sformatf("v%0d_wen_ren_both", i), 32'(both), 32'd0);
    if (v.we) begin
      chk($sformatf("v%0d_waddr", i), 32'(wa), 32'(v.addr));
      chk($sformatf("v%0d_wdata", i), wd, v.wdata);
      chk($sformatf("v%0d_wstrb", i), 32'(ws), 32'(v.strb));
    end
  endtask

  initial begin
    int q[$];
    int n;
    bit dbl, both, p0, p1;
    //          m  we addr      wdata          strb  lat sdata          err rdata          cyc str
    vecs[0] = '{0, 1, 16'h0004, 32'h0000ABCD, 4'h3, 0,  32'h0,         0, 32'h0,          2,  1};
    vecs[1] = '{1, 0, 16'h0008, 32'h0,        4'h0, 1,  32'h5A,        0, 32'h5A,         3,  2};
    vecs[2] = '{0, 0, 16'h0010, 32'h0,        4'h0, 99, 32'hDEADBEEF,  1, 32'h0,          17, 16};
    vecs[3] = '{0, 0, 16'h0010, 32'h0,        4'h0, 1,  32'h12345678,  0, 32'h12345678,   3,  2};
    vecs[4] = '{0, 1, 16'h0020, 32'h11112222, 4'hF, 15, 32'h0,         0, 32'h12345678,   17, 16};
    vecs[5] = '{0, 1, 16'h0024, 32'h33334444, 4'h1, 16, 32'h0,         1, 32'h12345678,   17, 16};
    vecs[6] = '{1, 1, 16'h0030, 32'h55556666, 4'hC, 3,  32'h0,         0, 32'h5A,         5,  4};
    vecs[7] = '{1, 0, 16'h0034, 32'h0,        4'h0, 5,  32'hCAFEF00D,  0, 32'hCAFEF00D,   7,  6};
    vecs[8] = '{0, 0, 16'h0038, 32'h0,        4'h0, 99, 32'hFFFFFFFF,  1, 32'h0,          17, 16};
    vecs[9] = '{0, 0, 16'h003C, 32'h0,        4'h0, 14, 32'h0BADF00D,  0, 32'h0BADF00D,   16, 15};

    rst = 1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_s_wen", 32'(s_wen), 32'd0);
    chk("rst_s_ren", 32'(s_ren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_errs", {30'd0, m1_err, m0_err}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_s_addr", {s_waddr, s_raddr}, 32'd0);
    chk("rst_s_wdata", {s_wdata[31:4], s_wstrb}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while m1 read is stalled in RD.
    @(negedge clk);
    rlat = 99;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0050;
    repeat (4) @(negedge clk);
    chk("pre_rst_ren", 32'(s_ren), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1; m1_req = 0;
    @(negedge clk);
    chk("mid_rst_ren", 32'(s_ren), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("mid_rst_m1_rdata", m1_rdata, 32'd0);
    rst = 0;

    // Both masters request continuously: m0 writes, m1 reads; m0 must win first.
    m0_req = 1; m0_we = 1; m0_addr = 16'h0040; m0_wdata = 32'h0000_1111; m0_wstrb = 4'hF;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0044;
    wlat = 0; rlat = 1; sdata = 32'h77;
    dbl = 0; both = 0; p0 = 0; p1 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m0_ack) q.push_back(0);
      if (m1_ack) q.push_back(1);
      if ((p0 && m0_ack) || (p1 && m1_ack) || (m0_ack && m1_ack)) dbl = 1;
      if (s_wen && s_ren) both = 1;
      p0 = m0_ack; p1 = m1_ack;
    end
    m0_req = 0; m1_req = 0;
    n = q.size();
    chk("alt_ack_count_ge4", 32'(n >= 4), 32'd1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("alt_grant%0d", k), (k < n) ? q[k] : 9, k % 2);
    chk("alt_ack_single_pulse", 32'(dbl), 32'd0);
    chk("alt_wen_ren_both", 32'(both), 32'd0);
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    chk("alt_drain_idle", 32'(busy), 32'd0);
    chk("alt_m1_rdata", m1_rdata, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
